// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and widths for the data memory arbiter
package data_mem_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef enum logic {
        PRIO0,
        FORCE1
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter in front of the single-port data memory
module data_mem_arbiter #(
    parameter int ADDR_W     = data_mem_pkg::ADDR_W,
    parameter int DATA_W     = data_mem_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic              P0_VALID,
    input  logic              P0_WE,
    input  logic [ADDR_W-1:0] P0_ADDR,
    input  logic [DATA_W-1:0] P0_WDATA,
    output logic              P0_READY,
    input  logic              P1_VALID,
    input  logic              P1_WE,
    input  logic [ADDR_W-1:0] P1_ADDR,
    input  logic [DATA_W-1:0] P1_WDATA,
    output logic              P1_READY,
    output logic              RSP_VALID,
    output logic              RSP_PORT,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              MEM_W_EN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_D_IN,
    input  logic [DATA_W-1:0] MEM_D_OUT
);
    import data_mem_pkg::*;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              gnt0, gnt1, gnt;
    mem_req_t          req;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q, rsp_port_q;

    // Grant selection; both grants are forced low while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            PRIO0: begin
                gnt0 = P0_VALID;
                gnt1 = P1_VALID && !P0_VALID;
            end
            FORCE1: begin
                gnt1 = P1_VALID;
            end
            default: begin
                gnt0 = 1'b0;
                gnt1 = 1'b0;
            end
        endcase
        gnt0 = gnt0 && RST_N;
        gnt1 = gnt1 && RST_N;
        gnt  = gnt0 || gnt1;
    end

    always_comb begin
        starve_d = starve_q;
        if (!P1_VALID || gnt1) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Forcing is decided on the incremented count so the grant lands right after the last denial.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIO0:   if (starve_d == STARVE_LIM) state_d = FORCE1;
            FORCE1:  if (gnt1 || !P1_VALID) state_d = PRIO0;
            default: state_d = PRIO0;
        endcase
    end

    always_comb begin
        req.we    = P0_WE;
        req.addr  = P0_ADDR;
        req.wdata = P0_WDATA;
        if (gnt1) begin
            req.we    = P1_WE;
            req.addr  = P1_ADDR;
            req.wdata = P1_WDATA;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= PRIO0;
            starve_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rsp_valid_q <= gnt && !req.we;
            rsp_port_q  <= gnt1;
            if (gnt) begin
                addr_q  <= req.addr;
                wdata_q <= req.wdata;
            end
        end
    end

    assign P0_READY  = gnt0;
    assign P1_READY  = gnt1;
    assign MEM_W_EN  = gnt && req.we;
    assign MEM_ADDR  = gnt ? req.addr  : addr_q;
    assign MEM_D_IN  = gnt ? req.wdata : wdata_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_PORT  = rsp_port_q;
    assign RSP_RDATA = MEM_D_OUT;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        RST_N;
    logic        P0_VALID, P0_WE, P0_READY;
    logic [9:0]  P0_ADDR;
    logic [31:0] P0_WDATA;
    logic        P1_VALID, P1_WE, P1_READY;
    logic [9:0]  P1_ADDR;
    logic [31:0] P1_WDATA;
    logic        RSP_VALID, RSP_PORT;
    logic [31:0] RSP_RDATA;
    logic        MEM_W_EN;
    logic [9:0]  MEM_ADDR;
    logic [31:0] MEM_D_IN;
    logic [31:0] MEM_D_OUT;

    int total = 0;
    int bad   = 0;

    data_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .RST_N(RST_N),
        .P0_VALID(P0_VALID), .P0_WE(P0_WE), .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA), .P0_READY(P0_READY),
        .P1_VALID(P1_VALID), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA), .P1_READY(P1_READY),
        .RSP_VALID(RSP_VALID), .RSP_PORT(RSP_PORT), .RSP_RDATA(RSP_RDATA),
        .MEM_W_EN(MEM_W_EN), .MEM_ADDR(MEM_ADDR), .MEM_D_IN(MEM_D_IN), .MEM_D_OUT(MEM_D_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory stand-in: sync write, registered read, driven from values sampled mid-cycle.
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic        s_we;
    logic [9:0]  s_addr;
    logic [31:0] s_din;
    bit          mem_loaded = 1'b0;

    always @(negedge clk) begin
        s_we   <= MEM_W_EN;
        s_addr <= MEM_ADDR;
        s_din  <= MEM_D_IN;
    end

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 + 32'(i);
            mem[5] = 32'hDEADBEEF;
            mem_loaded = 1'b1;
        end
        MEM_D_OUT <= mem[s_addr];
        if (s_we) mem[s_addr] = s_din;
    end

    // Reference model: wait count of port 1, expected response, shadow memory.
    int          wait_cnt = 0;
    bit          e0 = 1'b0, e1 = 1'b0;
    bit          exp_rsp_valid = 1'b0;
    bit          exp_rsp_port  = 1'b0;
    logic [31:0] exp_rsp_data  = '0;
    logic [9:0]  last_addr     = '0;
    bit          last_known    = 1'b0;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hC0DE0000 + 32'(i);
        ref_mem[5] = 32'hDEADBEEF;
    end

    always @(negedge clk) begin
        bit       forced, ewe;
        logic [9:0]  ea;
        logic [31:0] ed;
        if (!RST_N) begin
            e0 = 1'b0;
            e1 = 1'b0;
            chk("rst_p0_ready", 32'(P0_READY), 32'd0);
            chk("rst_p1_ready", 32'(P1_READY), 32'd0);
            chk("rst_w_en", 32'(MEM_W_EN), 32'd0);
            chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        end else begin
            forced = (wait_cnt >= STARVE_MAX);
            e0  = P0_VALID && !forced;
            e1  = P1_VALID && (forced || !P0_VALID);
            ewe = (e0 && P0_WE) || (e1 && P1_WE);
            ea  = e1 ? P1_ADDR : P0_ADDR;
            ed  = e1 ? P1_WDATA : P0_WDATA;
            chk("m_p0_ready", 32'(P0_READY), 32'(e0));
            chk("m_p1_ready", 32'(P1_READY), 32'(e1));
            chk("m_w_en", 32'(MEM_W_EN), 32'(ewe));
            if (e0 || e1) begin
                chk("m_addr", 32'(MEM_ADDR), 32'(ea));
                if (ewe) chk("m_din", MEM_D_IN, ed);
            end else if (last_known) begin
                chk("m_addr_hold", 32'(MEM_ADDR), 32'(last_addr));
            end
            chk("m_rsp_valid", 32'(RSP_VALID), 32'(exp_rsp_valid));
            if (exp_rsp_valid) begin
                chk("m_rsp_port", 32'(RSP_PORT), 32'(exp_rsp_port));
                chk("m_rsp_data", RSP_RDATA, exp_rsp_data);
            end
        end
    end

    always @(posedge clk) begin
        logic [9:0] a;
        if (!RST_N) begin
            wait_cnt      = 0;
            exp_rsp_valid = 1'b0;
            last_known    = 1'b0;
        end else begin
            if (P1_VALID && !e1) wait_cnt = wait_cnt + 1;
            else                 wait_cnt = 0;
            exp_rsp_valid = 1'b0;
            if (e0 || e1) begin
                a          = e1 ? P1_ADDR : P0_ADDR;
                last_addr  = a;
                last_known = 1'b1;
                if ((e1 && P1_WE) || (e0 && P0_WE)) begin
                    ref_mem[a] = e1 ? P1_WDATA : P0_WDATA;
                end else begin
                    exp_rsp_valid = 1'b1;
                    exp_rsp_port  = e1;
                    exp_rsp_data  = ref_mem[a];
                end
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        P0_VALID = 1'b0;
        P1_VALID = 1'b0;
        P0_WE    = 1'b0;
        P1_WE    = 1'b0;
    endtask

    logic [31:0] exp_stream [8];

    initial begin
        for (int i = 0; i < 8; i++) exp_stream[i] = 32'hC0DE0000 + 32'(i);
        exp_stream[5] = 32'hDEADBEEF;

        RST_N = 1'b0;
        idle();
        P0_ADDR = '0; P0_WDATA = '0; P1_ADDR = '0; P1_WDATA = '0;
        P0_VALID = 1'b1;
        P1_VALID = 1'b1;
        @(negedge clk);
        chk("reset_p0_ready_gated", 32'(P0_READY), 32'd0);
        chk("reset_p1_ready_gated", 32'(P1_READY), 32'd0);
        chk("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("reset_rsp_port", 32'(RSP_PORT), 32'd0);
        go(); idle();
        go(); RST_N = 1'b1;
        go();

        // Single port 1 read
        P1_VALID = 1'b1; P1_WE = 1'b0; P1_ADDR = 10'h005;
        @(negedge clk);
        chk("p1_read_ready", 32'(P1_READY), 32'd1);
        go(); idle();
        @(negedge clk);
        chk("p1_read_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("p1_read_rsp_port", 32'(RSP_PORT), 32'd1);
        chk("p1_read_rsp_data", RSP_RDATA, 32'hDEADBEEF);

        // Contention
        go();
        P0_VALID = 1'b1; P0_WE = 1'b1; P0_ADDR = 10'h010; P0_WDATA = 32'h12345678;
        P1_VALID = 1'b1; P1_WE = 1'b0; P1_ADDR = 10'h020;
        @(negedge clk);
        chk("cont_p0_ready", 32'(P0_READY), 32'd1);
        chk("cont_p1_ready", 32'(P1_READY), 32'd0);
        chk("cont_w_en", 32'(MEM_W_EN), 32'd1);
        chk("cont_addr", 32'(MEM_ADDR), 32'h010);
        go(); idle();
        go();

        // Starvation: port 1 denied four times, granted on the fifth
        P0_VALID = 1'b1; P0_WE = 1'b0; P0_ADDR = 10'h001;
        P1_VALID = 1'b1; P1_WE = 1'b0; P1_ADDR = 10'h002;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("starve_p1_denied", 32'(P1_READY), 32'd0);
            chk("starve_p0_granted", 32'(P0_READY), 32'd1);
            go();
        end
        @(negedge clk);
        chk("starve_p1_forced", 32'(P1_READY), 32'd1);
        chk("starve_p0_stalled", 32'(P0_READY), 32'd0);
        go();
        P1_ADDR = 10'h003;
        @(negedge clk);
        chk("starve_rsp_port", 32'(RSP_PORT), 32'd1);
        chk("starve_rsp_data", RSP_RDATA, 32'hC0DE0002);
        chk("resume_p0_ready", 32'(P0_READY), 32'd1);
        chk("resume_p1_ready", 32'(P1_READY), 32'd0);
        go(); idle();
        go();

        // Write then read of the same address
        P0_VALID = 1'b1; P0_WE = 1'b1; P0_ADDR = 10'h3FF; P0_WDATA = 32'hA5A5A5A5;
        go();
        P0_WE = 1'b0;
        go(); idle();
        @(negedge clk);
        chk("raw_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("raw_rsp_port", 32'(RSP_PORT), 32'd0);
        chk("raw_rsp_data", RSP_RDATA, 32'hA5A5A5A5);
        go();

        // Reset right after a read grant
        P1_VALID = 1'b1; P1_WE = 1'b0; P1_ADDR = 10'h006;
        go();
        idle();
        RST_N = 1'b0;
        P0_VALID = 1'b1; P0_WE = 1'b1; P0_ADDR = 10'h007; P0_WDATA = 32'h0BAD0BAD;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("midrst_w_en", 32'(MEM_W_EN), 32'd0);
        chk("midrst_p0_ready", 32'(P0_READY), 32'd0);
        go(); go();
        RST_N = 1'b1;
        P0_VALID = 1'b1; P0_WE = 1'b0; P0_ADDR = 10'h005;
        @(negedge clk);
        chk("postrst_p0_ready", 32'(P0_READY), 32'd1);
        go(); idle();
        @(negedge clk);
        chk("postrst_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("postrst_rsp_port", 32'(RSP_PORT), 32'd0);
        chk("postrst_rsp_data", RSP_RDATA, 32'hDEADBEEF);
        go();

        // Streaming reads from port 1
        for (int i = 0; i < 8; i++) begin
            P1_VALID = 1'b1; P1_WE = 1'b0; P1_ADDR = 10'(i);
            @(negedge clk);
            chk("stream_ready", 32'(P1_READY), 32'd1);
            if (i > 0) begin
                chk("stream_rsp_valid", 32'(RSP_VALID), 32'd1);
                chk("stream_rsp_data", RSP_RDATA, exp_stream[i-1]);
            end
            go();
        end
        idle();
        @(negedge clk);
        chk("stream_last_valid", 32'(RSP_VALID), 32'd1);
        chk("stream_last_data", RSP_RDATA, exp_stream[7]);
        go();
        @(negedge clk);
        chk("stream_done_valid", 32'(RSP_VALID), 32'd0);
        go();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
